// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver -- 8N1 UART receiver with single-byte holding register.
//
// The serial line is brought into the clock domain through a two-flop
// synchronizer. A five-state FSM finds the start bit, samples it at its
// midpoint, then samples each data bit and the stop bit one bit period
// apart. A correctly framed byte is loaded into the holding register and
// flagged with data_ready until the host acknowledges it with rd.
//
// Parameters
//   CLKS_PER_BIT   system clocks per UART bit period
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   reset          asynchronous active-low reset
//   RxD            serial input, idle high, 8N1, LSB first
//   rd             one-cycle read strobe acknowledging the held byte
//   data           last correctly framed byte
//   data_ready     an unread byte is held in data
//   overrun        sticky: a byte arrived while the previous was unread
//   framing_error  one-cycle pulse when a stop bit is sampled low
//   busy           FSM is anywhere but IDLE
// ---------------------------------------------------------------------------
module receiver #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rd,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       overrun,
    output logic       framing_error,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // Stage p0 / s: two-flop synchronizer; flops reset high so that a
    // released reset never looks like a start edge.
    logic rx_p0;
    logic rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= RxD;
            rx_s  <= rx_p0;
        end
    end

    // Receive FSM: registered state, combinational next state.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_done;
    logic             stop_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        stop_err  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                // Half a bit after the falling edge: a line that has gone
                // high again was a glitch, not a start bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                // A held-low line (break) must not be read as a new start
                // bit; wait for the line to return to idle first.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Host-side holding register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data          <= 8'h00;
            data_ready    <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= stop_err;
            if (byte_done) begin
                data       <= shreg_q;
                data_ready <= 1'b1;
                // A read landing on the completion cycle consumed the old
                // byte, so nothing was lost.
                if (rd) begin
                    overrun <= 1'b0;
                end else if (data_ready) begin
                    overrun <= 1'b1;
                end
            end else if (rd) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       RxD;
    logic       rd;
    logic [7:0] data;
    logic       data_ready;
    logic       overrun;
    logic       framing_error;
    logic       busy;

    receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .RxD           (RxD),
        .rd            (rd),
        .data          (data),
        .data_ready    (data_ready),
        .overrun       (overrun),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    int         fe_hi = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_dr(input int maxc);
        int n;
        n = 0;
        while (!data_ready && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("dr_wait", {31'd0, data_ready}, 32'd1);
    endtask

    // Scoreboard monitor: a completion shows up as data_ready rising, the
    // held byte changing while ready, or overrun rising.
    logic       prev_dr   = 1'b0;
    logic       prev_ovr  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            if (data_ready && (!prev_dr || data != prev_data || (overrun && !prev_ovr))) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (framing_error) fe_hi++;
        end
        prev_dr   = data_ready;
        prev_ovr  = overrun;
        prev_data = data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int fe_base;

        reset = 1'b0;
        RxD   = 1'b1;
        rd    = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_dr",   {31'd0, data_ready}, 32'd0);
        chk("rst_ovr",  {31'd0, overrun}, 32'd0);
        chk("rst_fe",   {31'd0, framing_error}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Clean 0x55
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        chk("f55_dr",  {31'd0, data_ready}, 32'd1);
        chk("f55_fe",  fe_hi, 32'd0);
        chk("f55_ovr", {31'd0, overrun}, 32'd0);
        pulse_rd();
        chk("f55_rd_dr", {31'd0, data_ready}, 32'd0);

        // Four-clock low glitch on an idle line
        busy_cnt = 0;
        RxD = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) RxD = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("glitch_busy_le10", {31'd0, (busy_cnt > 0 && busy_cnt <= 10)}, 32'd1);
        chk("glitch_busy_end",  {31'd0, busy}, 32'd0);
        chk("glitch_dr",        {31'd0, data_ready}, 32'd0);

        // 0xA3 with a low stop bit, then a 50-cycle break
        fe_base = fe_hi;
        send_frame(8'hA3, 1'b0);
        repeat (50) @(negedge clk);
        chk("fe_pulse_len", fe_hi - fe_base, 32'd1);
        chk("fe_dr",        {31'd0, data_ready}, 32'd0);
        chk("break_busy",   {31'd0, busy}, 32'd1);
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_release_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        chk("f3c_dr", {31'd0, data_ready}, 32'd1);
        pulse_rd();

        // Overrun: 0x11 then 0x22 without reading
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        chk("ovr_first_ovr", {31'd0, overrun}, 32'd0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        chk("ovr_data", {24'd0, data}, 32'h22);
        chk("ovr_dr",   {31'd0, data_ready}, 32'd1);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        pulse_rd();
        chk("ovr_rd_dr",  {31'd0, data_ready}, 32'd0);
        chk("ovr_rd_ovr", {31'd0, overrun}, 32'd0);

        // Reset during bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (CPB / 2) @(negedge clk);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        RxD   = 1'b1;
        @(negedge clk);
        chk("abort_data", {24'd0, data}, 32'h00);
        chk("abort_dr",   {31'd0, data_ready}, 32'd0);
        chk("abort_ovr",  {31'd0, overrun}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        chk("f81_data", {24'd0, data}, 32'h81);
        pulse_rd();

        // Back-to-back 0x01, 0x80 with a read after each
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        fork
            begin
                send_frame(8'h01, 1'b1);
                send_frame(8'h80, 1'b1);
            end
            begin
                wait_dr(400);
                chk("b2b_first_ovr", {31'd0, overrun}, 32'd0);
                pulse_rd();
                wait_dr(400);
                chk("b2b_second_ovr", {31'd0, overrun}, 32'd0);
                pulse_rd();
            end
        join
        repeat (4) @(negedge clk);
        chk("b2b_dr",  {31'd0, data_ready}, 32'd0);
        chk("b2b_ovr", {31'd0, overrun}, 32'd0);
        chk("b2b_data", {24'd0, data}, 32'h80);

        repeat (20) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
